// File: rtl/wb_sched_pkg.sv
// Shared definitions for the write-back scheduler.
// Holds the WD mux source codes, the constant written by the stack-pointer
// init sequence, the scheduler state encodings and the round-robin pointer
// advance helper.
package wb_sched_pkg;

  // WD mux select codes
  localparam logic [2:0] SRC_ALU    = 3'd0;
  localparam logic [2:0] SRC_MEM    = 3'd1;
  localparam logic [2:0] SRC_HI     = 3'd2;
  localparam logic [2:0] SRC_LO     = 3'd3;
  localparam logic [2:0] SRC_SHIFT  = 3'd4;
  localparam logic [2:0] SRC_LINK   = 3'd5;
  localparam logic [2:0] SRC_SPINIT = 3'd6;

  // Value the WD mux presents on SRC_SPINIT
  localparam logic [7:0] SP_INIT_VAL = 8'd227;

  // Scheduler states
  localparam logic [1:0] ST_INIT_SP   = 2'd0;
  localparam logic [1:0] ST_RUN       = 2'd1;
  localparam logic [1:0] ST_LOAD_WAIT = 2'd2;

  // Pointer value after granting src: src+1, wrapping 5 -> 0
  function automatic logic [2:0] ptr_after(logic [2:0] src);
    return (src >= SRC_LINK) ? SRC_ALU : src + 3'd1;
  endfunction

endpackage

// File: rtl/wb_sched_rr_pick6.sv
// Combinational round-robin picker over six requesters.
// Ports:
//   elig_i   - eligible request vector
//   ptr_i    - index searched first; search runs upward, wrapping mod 6
//   winner_o - index of the first eligible requester found
//   valid_o  - high when any requester is eligible
module rr_pick6 (
  input  logic [5:0] elig_i,
  input  logic [2:0] ptr_i,
  output logic [2:0] winner_o,
  output logic       valid_o
);

  logic [2:0] base;
  logic [2:0] idx;

  // Out-of-range pointers (6, 7) never occur; fold them onto 0 anyway.
  assign base = (ptr_i > 3'd5) ? 3'd0 : ptr_i;

  // Walk offsets from far to near so the nearest eligible index wins.
  always_comb begin
    winner_o = 3'd0;
    valid_o  = 1'b0;
    idx      = 3'd0;
    for (int k = 5; k >= 0; k--) begin
      if (base >= 3'(6 - k)) begin
        idx = base - 3'(6 - k);
      end else begin
        idx = base + 3'(k);
      end
      if (elig_i[idx]) begin
        winner_o = idx;
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_sched.sv
// Write-back scheduler for the register-bank write port.
// Issues the stack-pointer init write after reset, then arbitrates six
// write-back sources round-robin, one write per cycle. The memory source can
// be held for LOAD_WAIT extra cycles until its data settles at the WD mux.
// Ports:
//   clk, reset - clock (rising edge), asynchronous active-low reset
//   req        - per-source request, held until granted
//   req_addr   - packed 5-bit destination addresses, source i at [5i+4:5i]
//   gnt        - one-hot grant pulse, coincides with the write cycle
//   wd_sel     - WD mux select (0..5 sources, 6 = SP init constant)
//   wr_addr    - register bank write address
//   reg_wr     - register bank write enable (never for register 0)
//   init_done  - sticky, set once the SP init write is issued
//   busy       - not in RUN, or a write is in progress
module wb_sched
  import wb_sched_pkg::*;
#(
  parameter int unsigned NSRC      = 6,
  parameter int unsigned LOAD_WAIT = 1,
  parameter int unsigned SP_ADDR   = 29
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NSRC-1:0]   req,
  input  logic [5*NSRC-1:0] req_addr,
  output logic [NSRC-1:0]   gnt,
  output logic [2:0]        wd_sel,
  output logic [4:0]        wr_addr,
  output logic              reg_wr,
  output logic              init_done,
  output logic              busy
);

  logic [1:0]      state_q, state_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [NSRC-1:0] gnt_q, gnt_d;
  logic [2:0]      wd_sel_q, wd_sel_d;
  logic [4:0]      wr_addr_q, wr_addr_d;
  logic            reg_wr_q, reg_wr_d;
  logic            init_done_q, init_done_d;

  logic [NSRC-1:0] eligible;
  logic [2:0]      win;
  logic            win_vld;
  logic [4:0]      win_addr;

  // A requester still raising req during its own grant cycle is masked out.
  assign eligible = req & ~gnt_q;

  rr_pick6 u_pick (
    .elig_i   (eligible),
    .ptr_i    (ptr_q),
    .winner_o (win),
    .valid_o  (win_vld)
  );

  always_comb begin
    win_addr = 5'd0;
    for (int i = 0; i < NSRC; i++) begin
      if (win == 3'(i)) begin
        win_addr = req_addr[5*i +: 5];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    gnt_d       = '0;
    wd_sel_d    = wd_sel_q;
    wr_addr_d   = wr_addr_q;
    reg_wr_d    = 1'b0;
    init_done_d = init_done_q;
    case (state_q)
      ST_INIT_SP: begin
        wd_sel_d    = SRC_SPINIT;
        wr_addr_d   = 5'(SP_ADDR);
        reg_wr_d    = 1'b1;
        init_done_d = 1'b1;
        state_d     = ST_RUN;
      end
      ST_RUN: begin
        if (win_vld) begin
          wd_sel_d  = win;
          wr_addr_d = win_addr;
          if ((win == SRC_MEM) && (LOAD_WAIT != 0)) begin
            // Select the memory source now; the grant waits for its data.
            state_d = ST_LOAD_WAIT;
            cnt_d   = 3'(LOAD_WAIT);
          end else begin
            gnt_d[win] = 1'b1;
            reg_wr_d   = (win_addr != 5'd0);
            ptr_d      = ptr_after(win);
          end
        end
      end
      ST_LOAD_WAIT: begin
        if (cnt_q <= 3'd1) begin
          gnt_d[SRC_MEM] = 1'b1;
          reg_wr_d       = (wr_addr_q != 5'd0);
          ptr_d          = ptr_after(SRC_MEM);
          cnt_d          = 3'd0;
          state_d        = ST_RUN;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = ST_INIT_SP;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_INIT_SP;
      ptr_q       <= 3'd0;
      cnt_q       <= 3'd0;
      gnt_q       <= '0;
      wd_sel_q    <= 3'd0;
      wr_addr_q   <= 5'd0;
      reg_wr_q    <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      wd_sel_q    <= wd_sel_d;
      wr_addr_q   <= wr_addr_d;
      reg_wr_q    <= reg_wr_d;
      init_done_q <= init_done_d;
    end
  end

  assign gnt       = gnt_q;
  assign wd_sel    = wd_sel_q;
  assign wr_addr   = wr_addr_q;
  assign reg_wr    = reg_wr_q;
  assign init_done = init_done_q;
  assign busy      = (state_q != ST_RUN) || reg_wr_q;

endmodule

// File: doc/wb_sched.md
Name: wb_sched

Overview:
- Write-back scheduler for the register-bank write port.
- Arbitrates six write-back requesters (ALU, memory data, HI, LO, shifter, PC+4/link) and drives the 3-bit write-data mux select, the destination register address and the RegWrite strobe.
- After reset it performs the stack-pointer initialisation write: constant 227 into register 29 via mux select 3'b110.
- Sits between the control unit / functional units and the WD mux plus register bank.

Parameters:
- NSRC, 6, number of arbitrated requesters (select codes 0..NSRC-1).
- LOAD_WAIT, 1, extra cycles memory source 1 needs before its data is stable at the mux (0..7).
- SP_ADDR, 29, register written by the init sequence.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  6  per-source write-back request; held until granted.
- req_addr  in  30  packed destination addresses; source i uses bits [5i+4:5i].
- gnt  out  6  one-hot grant pulse, one cycle; coincides with the write cycle.
- wd_sel  out  3  WD mux select (000..101 sources, 110 = constant 227).
- wr_addr  out  5  register bank write address.
- reg_wr  out  1  register bank write enable.
- init_done  out  1  high once the SP init write has been issued.
- busy  out  1  high when the state is not RUN, or reg_wr is high.

Behaviour:
- Outputs are registered.
- Reset (reset=0, asynchronous) values: gnt=0, wd_sel=000, wr_addr=0, reg_wr=0, init_done=0, rr pointer=0, state=INIT_SP, wait counter=0.
- INIT_SP: on the first rising edge after reset deasserts, drive wd_sel=110, wr_addr=SP_ADDR, reg_wr=1, gnt=0 for exactly one cycle. Then set init_done=1 (sticky until reset) and go to RUN. req is ignored during INIT_SP.
- RUN, arbitration:
  - Eligible set = req & ~gnt. The current gnt mask prevents re-granting a requester that has not yet dropped req.
  - Winner is chosen round-robin, searching upward from the pointer and wrapping mod 6.
  - The pointer becomes winner+1 (wrapping 5 to 0) when the grant issues.
- RUN, winner i != 1 or LOAD_WAIT=0: at the next edge assert gnt[i]=1, wd_sel=i, wr_addr=req_addr[i], reg_wr=1. Latency is 1 cycle from req to write.
- RUN, winner i == 1 and LOAD_WAIT>0: go to LOAD_WAIT with wd_sel=001, wr_addr latched, reg_wr=0, gnt=0, counter=LOAD_WAIT.
- LOAD_WAIT: decrement the counter each cycle. When it reaches 1, the next edge issues gnt[1]=1 and reg_wr=1, and the state returns to RUN. All other requests stall, with the pointer unchanged, until then.
- Back-to-back: in the cycle gnt/reg_wr are high, arbitration runs again, giving a sustained throughput of one write per cycle.
- Idle: with no eligible request, reg_wr=0 and gnt=0. wd_sel and wr_addr hold their last values.
- Register 0: a request with addr=0 is granted normally (gnt pulse, wd_sel driven), but reg_wr=0.
- Requesters must hold req_addr stable from req assertion through their gnt cycle, and must drop req on the edge after gnt.
- wd_sel=111 is never driven.
- Reset mid-operation (any state, including LOAD_WAIT): immediate return to reset values. The pending write is lost with no gnt. INIT_SP repeats after release.
- Simultaneous requests from all six sources: each is served once within 6 grant cycles, in pointer order.

Decomposition:
- Shared package/include wb_defs:
  - source codes SRC_ALU=0, SRC_MEM=1, SRC_HI=2, SRC_LO=3, SRC_SHIFT=4, SRC_LINK=5, SRC_SPINIT=6;
  - SP_INIT_VAL=227;
  - state encodings INIT_SP=2'd0, RUN=2'd1, LOAD_WAIT=2'd2.
- One sub-module, rr_pick6: a combinational round-robin picker. Inputs are the 6-bit eligible vector and the 3-bit pointer. Outputs are the 3-bit winner index and a valid flag.

Test Plan:
- Release reset with req=6'b111111 -> first cycle wd_sel=110, wr_addr=29, reg_wr=1, gnt=0; init_done=1 afterwards; the first source grant arrives the following cycle, to source 0.
- Hold req=6'b111111 with LOAD_WAIT=0, each source dropping req after its gnt -> grants in order 0,1,2,3,4,5 on consecutive cycles, with wd_sel matching each grant and reg_wr=1 each cycle.
- req[1]=1, addr=8, LOAD_WAIT=2 -> wd_sel=001 for 2 cycles with reg_wr=0, then gnt[1]=1, reg_wr=1, wr_addr=8; a req[3] raised during the wait is granted the cycle after.
- req[0]=1 with addr=0 -> gnt[0] pulse, wd_sel=000, reg_wr=0.
- Assert reset during LOAD_WAIT -> gnt, reg_wr and init_done go to 0 immediately, with no write to the pending address; after release, INIT_SP repeats.
- Pointer=3 after a grant to source 2, then req=6'b000101 -> gnt[0] first, then gnt[2].
